// File: rtl/fetch_stage.sv
// Instruction fetch with a req/ack memory port, a one-entry skid buffer for decode stalls, and the IF/ID register.
// IF/ID loads on the edge after ack (1 instr/cycle at zero wait); stall holds IF/ID and drops req while the skid entry is full.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
  output logic [3:0]             opcode
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_plus1;
  } ifid_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                buf_vld_q, buf_vld_d;
  ifid_t               buf_q, buf_d;
  logic                ifid_vld_q, ifid_vld_d;
  ifid_t               ifid_q, ifid_d;

  logic [PC_WIDTH-1:0] pc_plus1;
  ifid_t               fetched;
  logic                ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      buf_vld_q     <= 1'b0;
      buf_q         <= '0;
      ifid_vld_q    <= 1'b0;
      ifid_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_vld_q     <= buf_vld_d;
      buf_q         <= buf_d;
      ifid_vld_q    <= ifid_vld_d;
      ifid_q        <= ifid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_vld_d     = buf_vld_q;
    buf_d         = buf_q;
    ifid_vld_d    = ifid_vld_q;
    ifid_d        = ifid_q;
    imem_req      = 1'b0;
    ack           = 1'b0;
    pc_plus1      = pc_q + PC_WIDTH'(1);
    fetched       = '{instr: imem_rdata, pc_plus1: pc_plus1};

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        // A full skid entry drains in the same cycle stall drops, so req may reassert then.
        imem_req = !buf_vld_q || !stall;
        ack      = imem_req && imem_ack;
        if (branch_taken) begin
          ifid_vld_d = 1'b0;
          buf_vld_d  = 1'b0;
          if (imem_req && !imem_ack) begin
            redirect_pc_d = branch_target;
            state_d       = ST_DISCARD;
          end else begin
            pc_d = branch_target;
          end
        end else if (stall) begin
          if (ack) begin
            buf_vld_d = 1'b1;
            buf_d     = fetched;
            pc_d      = pc_plus1;
          end
        end else if (buf_vld_q) begin
          ifid_vld_d = 1'b1;
          ifid_d     = buf_q;
          buf_vld_d  = ack;
          if (ack) begin
            buf_d = fetched;
            pc_d  = pc_plus1;
          end
        end else if (ack) begin
          ifid_vld_d = 1'b1;
          ifid_d     = fetched;
          pc_d       = pc_plus1;
        end else begin
          ifid_vld_d = 1'b0;
        end
      end

      ST_DISCARD: begin
        // The old request must complete before the redirect address can be issued.
        imem_req   = 1'b1;
        ifid_vld_d = 1'b0;
        buf_vld_d  = 1'b0;
        if (branch_taken) redirect_pc_d = branch_target;
        if (imem_ack) begin
          pc_d    = branch_taken ? branch_target : redirect_pc_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = ifid_vld_q;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus1 = ifid_q.pc_plus1;
  assign opcode         = ifid_vld_q ? ifid_q.instr[INSTR_WIDTH-1 -: 4] : 4'b0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-configurable memory returning base|addr, hand-computed IF/ID expectations.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [7:0]  if_id_pc_plus1;
  logic [3:0]  opcode;

  int          lat;
  int          wait_cnt;
  logic [15:0] base;
  logic        force_ack;
  int          checks;
  int          errors;

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .opcode         (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks in the lat-th cycle of a request (lat=1 is zero-wait).
  assign imem_ack   = force_ack || (imem_req && (wait_cnt == lat - 1));
  assign imem_rdata = base | {8'h00, imem_addr};

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] instr, input logic [7:0] pc1);
    check({tag, "_valid"}, if_id_valid, v);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_pc1"}, if_id_pc_plus1, pc1);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_addr;
    checks = 0;
    errors = 0;
    wait_cnt = 0;
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    lat = 1;
    base = 16'h0000;
    force_ack = 1'b0;

    // Reset values
    @(negedge clk);
    step();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check_ifid("rst", 1'b0, 16'h0000, 8'h00);
    check("rst_opcode", opcode, 4'h0);

    // Release: IDLE for one cycle, then zero-wait fetch of instr = addr
    rst = 1'b0;
    #1;
    check("idle_req", imem_req, 1'b0);
    step();
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 8'h00);
    check("first_valid", if_id_valid, 1'b0);
    check("first_opcode", opcode, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("zw", 1'b1, 16'(i), 8'(i + 1));
      check("zw_addr", imem_addr, 8'(i + 1));
    end

    // 3-cycle memory: address held, one instruction every 3 cycles
    lat = 3;
    base = 16'h3000;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_addr = 3 + k / 3;
      check("lat3_addr", imem_addr, 8'(exp_addr));
      check("lat3_req", imem_req, 1'b1);
      check("lat3_valid", if_id_valid, (k % 3) == 0);
      if ((k % 3) == 0) begin
        check("lat3_instr", if_id_instr, 16'h3000 + 16'(exp_addr - 1));
        check("lat3_opcode", opcode, 4'h3);
      end
    end

    // Stall 4 cycles; instr 5 captured in the skid buffer
    lat = 1;
    stall = 1'b1;
    #1;
    check("stall_req0", imem_req, 1'b1);
    check("stall_addr0", imem_addr, 8'h05);
    for (int i = 0; i < 4; i++) begin
      step();
      check_ifid("stall_hold", 1'b1, 16'h3004, 8'h05);
      check("stall_req", imem_req, 1'b0);
      check("stall_addr", imem_addr, 8'h06);
    end
    stall = 1'b0;
    #1;
    check("unstall_req", imem_req, 1'b1);
    check("unstall_addr", imem_addr, 8'h06);
    step();
    check_ifid("unstall_buf", 1'b1, 16'h3005, 8'h06);
    step();
    check_ifid("unstall_next", 1'b1, 16'h3006, 8'h07);
    check("unstall_addr2", imem_addr, 8'h08);

    // Branch to 0x40 while a 2-cycle fetch is outstanding
    lat = 2;
    step();
    check_ifid("drain", 1'b1, 16'h3007, 8'h08);
    step();
    check_ifid("lat2", 1'b1, 16'h3008, 8'h09);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    check("disc_valid", if_id_valid, 1'b0);
    check("disc_opcode", opcode, 4'h0);
    check("disc_req", imem_req, 1'b1);
    check("disc_addr", imem_addr, 8'h09);
    step();
    check("redir_valid", if_id_valid, 1'b0);
    check("redir_addr", imem_addr, 8'h40);
    check("redir_req", imem_req, 1'b1);
    step();
    check("redir_wait_valid", if_id_valid, 1'b0);
    step();
    check_ifid("redir_instr", 1'b1, 16'h3040, 8'h41);
    check("redir_opcode", opcode, 4'h3);

    // Branch, stall and ack together with a full buffer
    lat = 1;
    stall = 1'b1;
    step();
    check("full_req", imem_req, 1'b0);
    check("full_addr", imem_addr, 8'h42);
    check_ifid("full_hold", 1'b1, 16'h3040, 8'h41);
    force_ack = 1'b1;
    step();
    check("ign_ack_addr", imem_addr, 8'h42);
    check_ifid("ign_ack_hold", 1'b1, 16'h3040, 8'h41);
    branch_taken = 1'b1;
    branch_target = 8'h20;
    step();
    branch_taken = 1'b0;
    force_ack = 1'b0;
    check("combo_valid", if_id_valid, 1'b0);
    check("combo_opcode", opcode, 4'h0);
    check("combo_addr", imem_addr, 8'h20);
    check("combo_req", imem_req, 1'b1);
    stall = 1'b0;
    step();
    check_ifid("combo_instr", 1'b1, 16'h3020, 8'h21);

    // Second branch during DISCARD overrides the first target
    lat = 3;
    branch_taken = 1'b1;
    branch_target = 8'h80;
    step();
    check("ovr_valid", if_id_valid, 1'b0);
    check("ovr_addr", imem_addr, 8'h21);
    branch_target = 8'h90;
    step();
    branch_taken = 1'b0;
    check("ovr_addr2", imem_addr, 8'h21);
    step();
    check("ovr_target", imem_addr, 8'h90);
    check("ovr_valid2", if_id_valid, 1'b0);

    // Reset pulsed mid-DISCARD
    branch_taken = 1'b1;
    branch_target = 8'h10;
    step();
    branch_taken = 1'b0;
    check("pre_rst_req", imem_req, 1'b1);
    check("pre_rst_addr", imem_addr, 8'h90);
    rst = 1'b1;
    #1;
    check("arst_req", imem_req, 1'b0);
    check("arst_addr", imem_addr, 8'h00);
    check_ifid("arst", 1'b0, 16'h0000, 8'h00);
    check("arst_opcode", opcode, 4'h0);
    step();
    rst = 1'b0;
    lat = 1;
    base = 16'h0000;
    #1;
    check("rel_req", imem_req, 1'b0);
    step();
    check("rel_addr", imem_addr, 8'h00);
    check("rel_req2", imem_req, 1'b1);
    step();
    check_ifid("rel_instr", 1'b1, 16'h0000, 8'h01);

    // PC wrap from 0xFF
    branch_taken = 1'b1;
    branch_target = 8'hFE;
    step();
    branch_taken = 1'b0;
    check("wrap_valid", if_id_valid, 1'b0);
    check("wrap_addr", imem_addr, 8'hFE);
    step();
    check_ifid("wrap_fe", 1'b1, 16'h00FE, 8'hFF);
    check("wrap_addr_ff", imem_addr, 8'hFF);
    step();
    check_ifid("wrap_ff", 1'b1, 16'h00FF, 8'h00);
    check("wrap_addr_00", imem_addr, 8'h00);
    step();
    check_ifid("wrap_00", 1'b1, 16'h0000, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
